// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr: round-robin arbiter from NCH per-channel request FIFOs onto a single RAM port.
// Requests that hit the MMIO window bypass RAM and complete in one cycle on the MMIO port.
module ram_arbiter_rr #(
    parameter int            NCH       = 2,
    parameter int            AW        = 64,
    parameter int            DW        = 64,
    parameter int            DEPTH     = 2,
    parameter logic [AW-1:0] MMIO_BASE = 64'h0000_0000_0200_0000,
    parameter logic [AW-1:0] MMIO_MASK = 64'hFFFF_FFFF_FFFF_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    i_req_valid,
    output logic [NCH-1:0]    o_req_ready,
    input  logic [NCH*AW-1:0] i_req_addr,
    input  logic [NCH-1:0]    i_req_wen,
    input  logic [NCH*DW-1:0] i_req_wdata,
    input  logic [NCH*3-1:0]  i_req_size,
    output logic [NCH-1:0]    o_rsp_valid,
    output logic [DW-1:0]     o_rsp_rdata,
    output logic              o_ram_valid,
    output logic [AW-1:0]     o_ram_addr,
    output logic              o_ram_wen,
    output logic [DW-1:0]     o_ram_wdata,
    output logic [2:0]        o_ram_size,
    input  logic              i_ram_ready,
    input  logic [DW-1:0]     i_ram_rdata,
    output logic              o_mmio_valid,
    output logic [AW-1:0]     o_mmio_addr,
    output logic              o_mmio_wen,
    output logic [DW-1:0]     o_mmio_wdata,
    input  logic [DW-1:0]     i_mmio_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(NCH);
    localparam int EW = AW + 1 + DW + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAM  = 2'd1,
        ST_MMIO = 2'd2
    } state_t;

    // FIFO storage: each entry is {addr, wen, wdata, size}
    logic [EW-1:0]  fifo_mem_r [NCH][DEPTH];
    logic [PW-1:0]  wr_ptr_r   [NCH];
    logic [PW-1:0]  rd_ptr_r   [NCH];
    logic [CW-1:0]  count_r    [NCH];
    logic [EW-1:0]  entry_s    [NCH];
    logic [NCH-1:0] full_s;
    logic [NCH-1:0] empty_s;
    logic [NCH-1:0] push_s;
    logic [NCH-1:0] pop_s;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [GW-1:0]  grant_r;
    logic [GW-1:0]  ptr_r;

    logic           hi_found_s;
    logic           lo_found_s;
    logic [GW-1:0]  hi_g_s;
    logic [GW-1:0]  lo_g_s;
    logic           arb_any_s;
    logic [GW-1:0]  arb_g_s;

    logic [EW-1:0]  head_s;
    logic [AW-1:0]  head_addr_s;
    logic           head_wen_s;
    logic [DW-1:0]  head_wdata_s;
    logic [2:0]     head_size_s;
    logic           mmio_hit_s;

    logic           rsp_fire_s;
    logic [NCH-1:0] rsp_valid_s;
    logic [DW-1:0]  rsp_rdata_s;

    logic           ram_valid_r;
    logic [AW-1:0]  ram_addr_r;
    logic           ram_wen_r;
    logic [DW-1:0]  ram_wdata_r;
    logic [2:0]     ram_size_r;
    logic           mmio_valid_r;
    logic [AW-1:0]  mmio_addr_r;
    logic           mmio_wen_r;
    logic [DW-1:0]  mmio_wdata_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Request packing, FIFO status flags and push enables
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            entry_s[c] = {i_req_addr[c*AW +: AW], i_req_wen[c],
                          i_req_wdata[c*DW +: DW], i_req_size[c*3 +: 3]};
            full_s[c]  = (count_r[c] == CW'(DEPTH));
            empty_s[c] = (count_r[c] == {CW{1'b0}});
            push_s[c]  = i_req_valid[c] & ~full_s[c];
        end
    end

    assign o_req_ready = ~full_s;
    assign pop_s       = rsp_valid_s;

    // Per-channel FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_r[c] <= {PW{1'b0}};
                rd_ptr_r[c] <= {PW{1'b0}};
                count_r[c]  <= {CW{1'b0}};
                for (int d = 0; d < DEPTH; d++) begin
                    fifo_mem_r[c][d] <= {EW{1'b0}};
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push_s[c]) begin
                    fifo_mem_r[c][wr_ptr_r[c]] <= entry_s[c];
                    wr_ptr_r[c]                <= ptr_inc(wr_ptr_r[c]);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= ptr_inc(rd_ptr_r[c]);
                end
                case ({push_s[c], pop_s[c]})
                    2'b10:   count_r[c] <= count_r[c] + CW'(1'b1);
                    2'b01:   count_r[c] <= count_r[c] - CW'(1'b1);
                    default: count_r[c] <= count_r[c];
                endcase
            end
        end
    end

    // Round-robin scan: lowest non-empty index at/above ptr, else lowest below it (wrap)
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_g_s     = {GW{1'b0}};
        lo_g_s     = {GW{1'b0}};
        for (int c = NCH - 1; c >= 0; c--) begin
            hi_g_s     = (!empty_s[c] && (GW'(c) >= ptr_r)) ? GW'(c) : hi_g_s;
            hi_found_s = hi_found_s | (!empty_s[c] && (GW'(c) >= ptr_r));
            lo_g_s     = (!empty_s[c] && (GW'(c) < ptr_r)) ? GW'(c) : lo_g_s;
            lo_found_s = lo_found_s | (!empty_s[c] && (GW'(c) < ptr_r));
        end
        arb_any_s = hi_found_s | lo_found_s;
        arb_g_s   = hi_found_s ? hi_g_s : lo_g_s;
    end

    assign head_s       = fifo_mem_r[arb_g_s][rd_ptr_r[arb_g_s]];
    assign head_addr_s  = head_s[EW-1 -: AW];
    assign head_wen_s   = head_s[DW+3];
    assign head_wdata_s = head_s[DW+2:3];
    assign head_size_s  = head_s[2:0];
    assign mmio_hit_s   = ((head_addr_s & MMIO_MASK) == (MMIO_BASE & MMIO_MASK));

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s && mmio_hit_s) begin
                    state_nxt_s = ST_MMIO;
                end else if (arb_any_s) begin
                    state_nxt_s = ST_RAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RAM: begin
                if (i_ram_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RAM;
                end
            end
            ST_MMIO: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Completion: same-cycle response to the granted channel, which also pops its FIFO
    always_comb begin
        rsp_fire_s  = 1'b0;
        rsp_rdata_s = {DW{1'b0}};
        case (state_r)
            ST_RAM: begin
                rsp_fire_s  = i_ram_ready;
                rsp_rdata_s = i_ram_rdata;
            end
            ST_MMIO: begin
                rsp_fire_s  = 1'b1;
                rsp_rdata_s = i_mmio_rdata;
            end
            default: begin
                rsp_fire_s  = 1'b0;
                rsp_rdata_s = {DW{1'b0}};
            end
        endcase
        rsp_valid_s = rsp_fire_s ? (NCH'(1'b1) << grant_r) : {NCH{1'b0}};
    end

    assign o_rsp_valid = rsp_valid_s;
    assign o_rsp_rdata = rsp_rdata_s;

    // State, grant/pointer and registered RAM/MMIO request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= {GW{1'b0}};
            ptr_r        <= {GW{1'b0}};
            ram_valid_r  <= 1'b0;
            ram_addr_r   <= {AW{1'b0}};
            ram_wen_r    <= 1'b0;
            ram_wdata_r  <= {DW{1'b0}};
            ram_size_r   <= 3'd0;
            mmio_valid_r <= 1'b0;
            mmio_addr_r  <= {AW{1'b0}};
            mmio_wen_r   <= 1'b0;
            mmio_wdata_r <= {DW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            ram_valid_r  <= (state_nxt_s == ST_RAM);
            mmio_valid_r <= (state_nxt_s == ST_MMIO);
            if ((state_r == ST_IDLE) && arb_any_s) begin
                grant_r <= arb_g_s;
                ptr_r   <= (arb_g_s == GW'(NCH - 1)) ? {GW{1'b0}} : (arb_g_s + GW'(1'b1));
                if (mmio_hit_s) begin
                    mmio_addr_r  <= head_addr_s;
                    mmio_wen_r   <= head_wen_s;
                    mmio_wdata_r <= head_wdata_s;
                end else begin
                    ram_addr_r   <= head_addr_s;
                    ram_wen_r    <= head_wen_s;
                    ram_wdata_r  <= head_wdata_s;
                    ram_size_r   <= head_size_s;
                end
            end
        end
    end

    assign o_ram_valid  = ram_valid_r;
    assign o_ram_addr   = ram_addr_r;
    assign o_ram_wen    = ram_wen_r;
    assign o_ram_wdata  = ram_wdata_r;
    assign o_ram_size   = ram_size_r;
    assign o_mmio_valid = mmio_valid_r;
    assign o_mmio_addr  = mmio_addr_r;
    assign o_mmio_wen   = mmio_wen_r;
    assign o_mmio_wdata = mmio_wdata_r;

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed testbench for ram_arbiter_rr (three channels, depth-2 FIFOs).
module tb_ram_arbiter_rr;

    localparam int NCH   = 3;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 2;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH-1:0]    req_wen;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH*3-1:0]  req_size;
    logic [NCH-1:0]    rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              ram_valid;
    logic [AW-1:0]     ram_addr;
    logic              ram_wen;
    logic [DW-1:0]     ram_wdata;
    logic [2:0]        ram_size;
    logic              ram_ready;
    logic [DW-1:0]     ram_rdata;
    logic              mmio_valid;
    logic [AW-1:0]     mmio_addr;
    logic              mmio_wen;
    logic [DW-1:0]     mmio_wdata;
    logic [DW-1:0]     mmio_rdata;

    int tests_run;
    int tests_failed;

    ram_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_wen    (req_wen),
        .i_req_wdata  (req_wdata),
        .i_req_size   (req_size),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_ram_valid  (ram_valid),
        .o_ram_addr   (ram_addr),
        .o_ram_wen    (ram_wen),
        .o_ram_wdata  (ram_wdata),
        .o_ram_size   (ram_size),
        .i_ram_ready  (ram_ready),
        .i_ram_rdata  (ram_rdata),
        .o_mmio_valid (mmio_valid),
        .o_mmio_addr  (mmio_addr),
        .o_mmio_wen   (mmio_wen),
        .o_mmio_wdata (mmio_wdata),
        .i_mmio_rdata (mmio_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [63:0] addr, input logic wen, input logic [63:0] wdata);
        req_valid[c]          = 1'b1;
        req_addr[c*AW +: AW]  = addr;
        req_wen[c]            = wen;
        req_wdata[c*DW +: DW] = wdata;
        req_size[c*3 +: 3]    = 3'd3;
    endtask

    task automatic clr_req();
        req_valid = {NCH{1'b0}};
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clr_req();
        ram_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_oh;
        logic [63:0] exp_addr;
        int g;
        int k;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = {NCH{1'b0}};
        req_addr     = {(NCH*AW){1'b0}};
        req_wen      = {NCH{1'b0}};
        req_wdata    = {(NCH*DW){1'b0}};
        req_size     = {(NCH*3){1'b0}};
        ram_ready    = 1'b0;
        ram_rdata    = 64'h0;
        mmio_rdata   = 64'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h7);
        chk("rst_ram_valid", 64'(ram_valid), 64'h0);
        chk("rst_mmio_valid", 64'(mmio_valid), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_ram_addr", ram_addr, 64'h0);
        chk("rst_mmio_addr", mmio_addr, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Stray RAM ready while idle
        ram_ready = 1'b1;
        #1;
        chk("idle_stray_rsp", 64'(rsp_valid), 64'h0);
        next_cycle();
        ram_ready = 1'b0;
        chk("idle_stray_ram_valid", 64'(ram_valid), 64'h0);

        // Single read: push at T
        set_req(0, 64'h8000_0000, 1'b0, 64'h0);
        next_cycle();
        clr_req();
        chk("t1_ram_valid_T1", 64'(ram_valid), 64'h0);
        next_cycle();
        chk("t1_ram_valid_T2", 64'(ram_valid), 64'h1);
        chk("t1_ram_addr", ram_addr, 64'h8000_0000);
        chk("t1_ram_wen", 64'(ram_wen), 64'h0);
        chk("t1_ram_size", 64'(ram_size), 64'h3);
        next_cycle();
        chk("t1_ram_valid_T3", 64'(ram_valid), 64'h1);
        chk("t1_rsp_T3", 64'(rsp_valid), 64'h0);
        next_cycle();
        ram_ready = 1'b1;
        ram_rdata = 64'hDEAD;
        #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_rdata", rsp_rdata, 64'hDEAD);
        next_cycle();
        ram_ready = 1'b0;
        chk("t1_ram_valid_T5", 64'(ram_valid), 64'h0);
        chk("t1_rsp_T5", 64'(rsp_valid), 64'h0);

        // Fairness: all channels hold two requests each
        do_reset();
        for (int c = 0; c < NCH; c++) set_req(c, 64'h8000_0000 + 64'(c) * 64'h100, 1'b0, 64'h0);
        next_cycle();
        for (int c = 0; c < NCH; c++) set_req(c, 64'h8000_0010 + 64'(c) * 64'h100, 1'b0, 64'h0);
        next_cycle();
        clr_req();
        for (int i = 0; i < 6; i++) begin
            g        = i % 3;
            k        = i / 3;
            exp_addr = 64'h8000_0000 + 64'(g) * 64'h100 + 64'(k) * 64'h10;
            exp_oh   = 64'h1 << g;
            chk($sformatf("fair%0d_ram_valid", i), 64'(ram_valid), 64'h1);
            chk($sformatf("fair%0d_ram_addr", i), ram_addr, exp_addr);
            ram_ready = 1'b1;
            ram_rdata = 64'h1000 + 64'(i);
            #1;
            chk($sformatf("fair%0d_rsp_valid", i), 64'(rsp_valid), exp_oh);
            chk($sformatf("fair%0d_rsp_rdata", i), rsp_rdata, 64'h1000 + 64'(i));
            next_cycle();
            ram_ready = 1'b0;
            chk($sformatf("fair%0d_bubble", i), 64'(ram_valid), 64'h0);
            next_cycle();
        end
        chk("fair_drained", 64'(ram_valid), 64'h0);

        // MMIO bypass write on channel 1
        do_reset();
        mmio_rdata = 64'h77;
        set_req(1, 64'h0200_4000, 1'b1, 64'h5);
        next_cycle();
        clr_req();
        chk("mmio_valid_A1", 64'(mmio_valid), 64'h0);
        chk("mmio_ram_A1", 64'(ram_valid), 64'h0);
        next_cycle();
        chk("mmio_valid", 64'(mmio_valid), 64'h1);
        chk("mmio_addr", mmio_addr, 64'h0200_4000);
        chk("mmio_wen", 64'(mmio_wen), 64'h1);
        chk("mmio_wdata", mmio_wdata, 64'h5);
        chk("mmio_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("mmio_rsp_rdata", rsp_rdata, 64'h77);
        chk("mmio_ram_A2", 64'(ram_valid), 64'h0);
        next_cycle();
        chk("mmio_valid_A3", 64'(mmio_valid), 64'h0);
        chk("mmio_rsp_A3", 64'(rsp_valid), 64'h0);
        chk("mmio_ram_A3", 64'(ram_valid), 64'h0);

        // Address just past the window goes to RAM
        set_req(2, 64'h0201_0000, 1'b0, 64'h0);
        next_cycle();
        clr_req();
        next_cycle();
        chk("win_edge_ram_valid", 64'(ram_valid), 64'h1);
        chk("win_edge_mmio_valid", 64'(mmio_valid), 64'h0);
        chk("win_edge_ram_addr", ram_addr, 64'h0201_0000);
        ram_ready = 1'b1;
        ram_rdata = 64'hBEEF;
        #1;
        chk("win_edge_rsp_valid", 64'(rsp_valid), 64'h4);
        next_cycle();
        ram_ready = 1'b0;

        // Full FIFO with RAM stalled
        do_reset();
        set_req(0, 64'h8000_1000, 1'b0, 64'h0);
        #1;
        chk("full_ready_A0", 64'(req_ready[0]), 64'h1);
        next_cycle();
        set_req(0, 64'h8000_2000, 1'b0, 64'h0);
        #1;
        chk("full_ready_A1", 64'(req_ready[0]), 64'h1);
        next_cycle();
        set_req(0, 64'h8000_3000, 1'b0, 64'h0);
        #1;
        chk("full_ready_A2", 64'(req_ready[0]), 64'h0);
        chk("full_ram_addr0", ram_addr, 64'h8000_1000);
        next_cycle();
        chk("full_ready_A3", 64'(req_ready[0]), 64'h0);
        ram_ready = 1'b1;
        #1;
        chk("full_rsp0", 64'(rsp_valid), 64'h1);
        next_cycle();
        ram_ready = 1'b0;
        #1;
        chk("full_ready_A4", 64'(req_ready[0]), 64'h1);
        chk("full_bubble_A4", 64'(ram_valid), 64'h0);
        next_cycle();
        clr_req();
        chk("full_ram_addr1", ram_addr, 64'h8000_2000);
        chk("full_ram_valid1", 64'(ram_valid), 64'h1);
        ram_ready = 1'b1;
        #1;
        chk("full_rsp1", 64'(rsp_valid), 64'h1);
        next_cycle();
        ram_ready = 1'b0;
        chk("full_bubble_A6", 64'(ram_valid), 64'h0);
        next_cycle();
        chk("full_ram_addr2", ram_addr, 64'h8000_3000);
        chk("full_ram_valid2", 64'(ram_valid), 64'h1);
        ram_ready = 1'b1;
        #1;
        chk("full_rsp2", 64'(rsp_valid), 64'h1);
        next_cycle();
        ram_ready = 1'b0;
        chk("full_ready_empty", 64'(req_ready), 64'h7);
        next_cycle();
        chk("full_no_dup", 64'(ram_valid), 64'h0);

        // Asynchronous reset in the middle of a RAM transaction
        do_reset();
        set_req(0, 64'h8000_4000, 1'b0, 64'h0);
        next_cycle();
        set_req(0, 64'h8000_5000, 1'b0, 64'h0);
        next_cycle();
        clr_req();
        chk("arst_pre_ram_valid", 64'(ram_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ram_valid", 64'(ram_valid), 64'h0);
        chk("arst_req_ready", 64'(req_ready), 64'h7);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'h0);
        #2;
        rst_n = 1'b1;
        next_cycle();
        ram_ready = 1'b1;
        ram_rdata = 64'h1234;
        #1;
        chk("arst_stray_rsp0", 64'(rsp_valid), 64'h0);
        chk("arst_ram_valid0", 64'(ram_valid), 64'h0);
        next_cycle();
        chk("arst_stray_rsp1", 64'(rsp_valid), 64'h0);
        ram_ready = 1'b0;
        next_cycle();
        chk("arst_fifo_dropped", 64'(ram_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
